i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
- Master-mode I2S serial transmitter for the codec DAC path. It is the driving end of the serial audio link that the receive side samples through its synchronizer and edge detectors.
- Generates bclk and lrclk from the system clock and shifts left/right samples out MSB-first on sdata, in I2S timing (MSB one bclk after the lrclk transition).
- Samples come from the effects pipeline through a valid/ready handshake into a one-frame holding buffer.

Parameters:
- DATA_WIDTH, 16: bits per sample; must satisfy DATA_WIDTH <= SLOT_BITS-1.
- SLOT_BITS, 32: bclk periods per channel slot (frame = 2*SLOT_BITS bits).
- BCLK_DIV, 4: system clocks per bclk half-period, >= 2. bclk period = 2*BCLK_DIV clocks.

Ports:
- clock  in  1  system clock; every register is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- leftSample  in  DATA_WIDTH  left-channel sample, two's complement.
- rightSample  in  DATA_WIDTH  right-channel sample.
- sampleValid  in  1  left/right pair presented.
- sampleReady  out  1  holding buffer empty; the pair is accepted on sampleValid&&sampleReady.
- bclk  out  1  serial bit clock.
- lrclk  out  1  word select: 0 = left slot, 1 = right slot.
- sdata  out  1  serial data.
- frameStart  out  1  one-clock pulse when a new frame begins.
- underrun  out  1  one-clock pulse when a frame starts with the holding buffer empty.

Behaviour:
- Reset values (while reset is high):
  - divCnt=0, bclk=0, lrclk=0, sdata=0, frameStart=0, underrun=0.
  - bitCnt=2*SLOT_BITS-1, so the first falling edge starts a frame.
  - holdFull=0; active shift registers=0.
- Divider:
  - divCnt counts 0..BCLK_DIV-1.
  - At divCnt==BCLK_DIV-1, bclk toggles and divCnt wraps to 0.
  - "Fall event" = the cycle in which bclk toggles 1->0.
  - All of bitCnt, lrclk, sdata, frameStart and underrun update only on fall events; the receiver samples on the bclk rising edge.
- Bit counter (on each fall event):
  - bitCnt increments mod 2*SLOT_BITS.
  - Then p = bitCnt mod SLOT_BITS.
  - lrclk = (bitCnt >= SLOT_BITS).
- sdata (registered on the fall event):
  - p==0: 0 (trailing pad of the previous slot).
  - 1<=p<=DATA_WIDTH: bit [DATA_WIDTH-p] of the current slot's sample (left if lrclk==0, right if lrclk==1), i.e. MSB at p=1, LSB at p=DATA_WIDTH.
  - p>DATA_WIDTH: 0.
- Frame start (fall event where bitCnt becomes 0):
  - frameStart pulses for that one clock.
  - If holdFull: the held pair is copied to the active left/right registers and holdFull is cleared.
  - Else: the active registers are loaded with 0 and underrun pulses for that clock.
  - Active registers change only at frame start, so a frame is never mixed from two sample pairs.
- Handshake:
  - sampleReady = ~holdFull (combinational); it is 1 during reset.
  - sampleValid&&sampleReady captures both samples and sets holdFull the next clock.
  - sampleValid while holdFull is ignored; the source must hold its data until ready.
- Simultaneous accept and frame start with holdFull=0:
  - The frame underruns (transmits 0).
  - The new pair is captured into holding and is used at the next frame start.
- Reset mid-frame:
  - All state returns to reset values the next clock, including bclk=0 and lrclk=0.
  - No partial bit is extended; any held pair is discarded.
- Rates at defaults: bclk = clock/8, frame = 512 clocks.

Test Plan:
- Reset release, no samples, defaults → bclk first rises 4 clocks after reset deasserts and has period 8. First fall event at clock 8 pulses frameStart and underrun. sdata stays 0 for the whole frame.
- Present left=16'hA5C3, right=16'h0F01 before the first frame start → accepted (ready 1→0). At frame start ready returns to 1.
  - Left slot: sdata at p=1..16 is 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1, with lrclk=0.
  - Right slot: lrclk=1 from bitCnt 32; p=1..16 carries 16'h0F01.
  - p=0 and p=17..31 are 0 in both slots.
- Hold sampleValid high with a new pair every accept → exactly one accept per 512 clocks. No underrun after the first frame. Consecutive frames carry consecutive pairs.
- Assert sampleValid in the exact clock of frame start with holding empty → underrun=1, frame transmits zeros, and the pair appears in the following frame.
- Assert reset for 1 clock at bitCnt=40 mid-transmission → next clock bclk=0, lrclk=0, sdata=0, sampleReady=1. Timing restarts exactly as in the first scenario.
- DATA_WIDTH=24, SLOT_BITS=32, BCLK_DIV=2, left=24'h800001 → MSB 1 at p=1, zeros through p=23, 1 at p=24, bclk period 4 clocks.

Source files
------------

// File: rtl/i2s_transmitter.sv
// Master-mode I2S transmitter: derives bclk/lrclk from the system clock and shifts a
// held left/right pair out MSB-first, one bclk after each lrclk transition.
module i2s_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] leftSample,
  input  logic [DATA_WIDTH-1:0] rightSample,
  input  logic                  sampleValid,
  output logic                  sampleReady,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  frameStart,
  output logic                  underrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]      div_cnt_r;
  logic                  bclk_r;
  logic [BIT_W-1:0]      bit_cnt_r;
  logic                  lrclk_r;
  logic                  sdata_r;
  logic                  frame_start_r;
  logic                  underrun_r;
  logic                  hold_full_r;
  logic [DATA_WIDTH-1:0] hold_left_r;
  logic [DATA_WIDTH-1:0] hold_right_r;
  logic [DATA_WIDTH-1:0] act_left_r;
  logic [DATA_WIDTH-1:0] act_right_r;

  logic                  fall_s;
  logic [BIT_W-1:0]      bit_next_s;
  logic                  lr_next_s;
  logic [BIT_W-1:0]      pos_s;
  logic                  frame_start_s;
  logic                  accept_s;
  logic [DATA_WIDTH-1:0] slot_word_s;
  logic [IDX_W-1:0]      idx_s;
  logic                  data_bit_s;

  // Next bit position, slot select and serial bit for the coming fall event.
  always_comb begin
    fall_s = bclk_r & (div_cnt_r == DIV_LAST);
    if (bit_cnt_r == BIT_LAST) begin
      bit_next_s = '0;
    end else begin
      bit_next_s = bit_cnt_r + BIT_W'(1);
    end
    lr_next_s = (bit_next_s >= SLOT_LEN);
    if (lr_next_s) begin
      pos_s = bit_next_s - SLOT_LEN;
    end else begin
      pos_s = bit_next_s;
    end
    frame_start_s = fall_s & (bit_next_s == '0);
    accept_s      = sampleValid & ~hold_full_r;
    if (lr_next_s) begin
      slot_word_s = act_right_r;
    end else begin
      slot_word_s = act_left_r;
    end
    idx_s = IDX_W'(DATA_LEN - pos_s);
    // Position 0 is the pad bit before the MSB; positions past the sample are zero fill.
    if ((pos_s >= BIT_W'(1)) && (pos_s <= DATA_LEN)) begin
      data_bit_s = slot_word_s[idx_s];
    end else begin
      data_bit_s = 1'b0;
    end
  end

  // Bit-clock divider: toggles bclk every BCLK_DIV system clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_r <= '0;
      bclk_r    <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
      bclk_r    <= ~bclk_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  // Serial side: bit counter, word select and data all move on bclk falling edges.
  always_ff @(posedge clock) begin
    if (reset) begin
      bit_cnt_r     <= BIT_LAST;
      lrclk_r       <= 1'b0;
      sdata_r       <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= frame_start_s;
      if (fall_s) begin
        bit_cnt_r <= bit_next_s;
        lrclk_r   <= lr_next_s;
        sdata_r   <= data_bit_s;
      end
    end
  end

  // Holding buffer and active pair: the active pair only changes at frame start.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_full_r  <= 1'b0;
      hold_left_r  <= '0;
      hold_right_r <= '0;
      act_left_r   <= '0;
      act_right_r  <= '0;
      underrun_r   <= 1'b0;
    end else begin
      underrun_r <= 1'b0;
      if (frame_start_s) begin
        if (hold_full_r) begin
          act_left_r  <= hold_left_r;
          act_right_r <= hold_right_r;
          hold_full_r <= 1'b0;
        end else begin
          act_left_r  <= '0;
          act_right_r <= '0;
          underrun_r  <= 1'b1;
        end
      end
      // An accept coinciding with an empty frame start still lands for the next frame.
      if (accept_s) begin
        hold_left_r  <= leftSample;
        hold_right_r <= rightSample;
        hold_full_r  <= 1'b1;
      end
    end
  end

  assign sampleReady = ~hold_full_r | reset;
  assign bclk        = bclk_r;
  assign lrclk       = lrclk_r;
  assign sdata       = sdata_r;
  assign frameStart  = frame_start_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: default build plus a 24-bit / fast-bclk build.
module tb_i2s_transmitter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [15:0] leftSample;
  logic [15:0] rightSample;
  logic        sampleValid;
  logic        sampleReady;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frameStart;
  logic        underrun;

  logic        rst24;
  logic [23:0] l24;
  logic [23:0] r24;
  logic        v24;
  logic        rdy24;
  logic        bclk24;
  logic        lrclk24;
  logic        sdata24;
  logic        fs24;
  logic        ur24;

  int          n_cmp;
  int          n_err;
  int          k;
  int          acc_cnt;
  int          idx;
  bit          b2b;
  logic [31:0] pairs [5];

  i2s_transmitter dut (
    .clock(clock), .reset(reset), .leftSample(leftSample), .rightSample(rightSample),
    .sampleValid(sampleValid), .sampleReady(sampleReady), .bclk(bclk), .lrclk(lrclk),
    .sdata(sdata), .frameStart(frameStart), .underrun(underrun)
  );

  i2s_transmitter #(.DATA_WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(2)) dut24 (
    .clock(clock), .reset(rst24), .leftSample(l24), .rightSample(r24),
    .sampleValid(v24), .sampleReady(rdy24), .bclk(bclk24), .lrclk(lrclk24),
    .sdata(sdata24), .frameStart(fs24), .underrun(ur24)
  );

  function automatic logic exp_bclk(input int kk);
    return ((kk / 4) % 2) == 1;
  endfunction

  // One system clock, negedge to negedge; advances the source on accepts.
  task automatic tick();
    logic acc;
    acc = sampleValid && sampleReady && !reset;
    @(posedge clock);
    @(negedge clock);
    k++;
    if (acc) begin
      acc_cnt++;
      if (b2b && idx < 4) begin
        idx++;
        {leftSample, rightSample} = pairs[idx];
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sampleValid = 1'b0; leftSample = 16'h0000; rightSample = 16'h0000;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({bclk, lrclk, sdata, frameStart, underrun, sampleReady} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_state: got %b want 000001", {bclk, lrclk, sdata, frameStart, underrun, sampleReady});
    end
    reset = 1'b0; k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({bclk, frameStart, underrun} !== {exp_bclk(k), k == 8, k == 8}) begin
        n_err++;
        $display("FAIL first_frame_k%0d: got bclk/fs/ur=%b want %b", k, {bclk, frameStart, underrun}, {exp_bclk(k), k == 8, k == 8});
      end
    end
  endtask

  task automatic test_idle_frame();
    while (k < 300) begin
      tick();
      n_cmp++;
      if ({bclk, lrclk, sdata} !== {exp_bclk(k), k >= 264, 1'b0}) begin
        n_err++;
        $display("FAIL idle_k%0d: got bclk/lrclk/sdata=%b want %b", k, {bclk, lrclk, sdata}, {exp_bclk(k), k >= 264, 1'b0});
      end
    end
  endtask

  task automatic test_single_pair();
    int p; logic [15:0] w; logic e;
    leftSample = 16'hA5C3; rightSample = 16'h0F01; sampleValid = 1'b1;
    n_cmp++;
    if (sampleReady !== 1'b1) begin n_err++; $display("FAIL ready_before_accept: got %b want 1", sampleReady); end
    tick();
    sampleValid = 1'b0;
    n_cmp++;
    if (sampleReady !== 1'b0) begin n_err++; $display("FAIL ready_after_accept: got %b want 0", sampleReady); end
    while (k < 519) begin
      tick();
      n_cmp++;
      if (sdata !== 1'b0) begin n_err++; $display("FAIL idle_tail_k%0d: got sdata %b want 0", k, sdata); end
    end
    tick();
    n_cmp++;
    if ({frameStart, underrun, sampleReady} !== 3'b101) begin
      n_err++; $display("FAIL pair_frame_start: got fs/ur/rdy=%b want 101", {frameStart, underrun, sampleReady});
    end
    for (int b = 0; b < 64; b++) begin
      p = b % 32;
      w = (b < 32) ? 16'hA5C3 : 16'h0F01;
      if (p >= 1 && p <= 16) e = w[16 - p]; else e = 1'b0;
      n_cmp++;
      if ({lrclk, sdata, bclk} !== {b >= 32, e, 1'b0}) begin
        n_err++; $display("FAIL pair_bit%0d: got lrclk/sdata/bclk=%b want %b", b, {lrclk, sdata, bclk}, {b >= 32, e, 1'b0});
      end
      repeat ((b == 63) ? 7 : 8) tick();
    end
  endtask

  task automatic test_sim_accept();
    int p;
    idx = 0; acc_cnt = 0; b2b = 1'b1;
    {leftSample, rightSample} = pairs[0];
    sampleValid = 1'b1;
    n_cmp++;
    if (sampleReady !== 1'b1) begin n_err++; $display("FAIL sim_ready: got %b want 1", sampleReady); end
    tick();
    n_cmp++;
    if ({frameStart, underrun, sampleReady} !== 3'b110) begin
      n_err++; $display("FAIL sim_frame_start: got fs/ur/rdy=%b want 110", {frameStart, underrun, sampleReady});
    end
    for (int b = 0; b < 64; b++) begin
      n_cmp++;
      if ({lrclk, sdata} !== {b >= 32, 1'b0}) begin
        n_err++; $display("FAIL sim_zero_bit%0d: got lrclk/sdata=%b want %b", b, {lrclk, sdata}, {b >= 32, 1'b0});
      end
      repeat (8) tick();
    end
  endtask

  task automatic test_back_to_back();
    int p; logic [15:0] w; logic e; logic [31:0] pr;
    for (int f = 0; f < 3; f++) begin
      pr = pairs[f];
      n_cmp++;
      if ({frameStart, underrun} !== 2'b10) begin
        n_err++; $display("FAIL b2b_start%0d: got fs/ur=%b want 10", f, {frameStart, underrun});
      end
      for (int b = 0; b < 64; b++) begin
        p = b % 32;
        w = (b < 32) ? pr[31:16] : pr[15:0];
        if (p >= 1 && p <= 16) e = w[16 - p]; else e = 1'b0;
        n_cmp++;
        if ({lrclk, sdata} !== {b >= 32, e}) begin
          n_err++; $display("FAIL b2b_f%0d_bit%0d: got lrclk/sdata=%b want %b", f, b, {lrclk, sdata}, {b >= 32, e});
        end
        repeat (8) tick();
      end
    end
    n_cmp++;
    if (acc_cnt !== 4) begin n_err++; $display("FAIL b2b_accepts: got %0d want 4", acc_cnt); end
    sampleValid = 1'b0; b2b = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] pr;
    pr = pairs[3];
    sampleValid = 1'b1;
    tick();
    sampleValid = 1'b0;
    n_cmp++;
    if (sampleReady !== 1'b0) begin n_err++; $display("FAIL mid_hold_full: got %b want 0", sampleReady); end
    while (k < 3405) tick();
    n_cmp++;
    if ({bclk, lrclk, sdata} !== {1'b1, 1'b1, pr[8]}) begin
      n_err++; $display("FAIL mid_before_reset: got bclk/lrclk/sdata=%b want %b", {bclk, lrclk, sdata}, {1'b1, 1'b1, pr[8]});
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({bclk, lrclk, sdata, sampleReady, frameStart, underrun} !== 6'b000100) begin
      n_err++; $display("FAIL mid_reset_state: got %b want 000100", {bclk, lrclk, sdata, sampleReady, frameStart, underrun});
    end
    reset = 1'b0; k = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if ({bclk, frameStart, underrun, sampleReady} !== {exp_bclk(k), k == 8, k == 8, 1'b1}) begin
        n_err++;
        $display("FAIL restart_k%0d: got %b want %b", k, {bclk, frameStart, underrun, sampleReady}, {exp_bclk(k), k == 8, k == 8, 1'b1});
      end
    end
  endtask

  task automatic test_dw24();
    int k2; int p; logic [23:0] w; logic e;
    l24 = 24'h800001; r24 = 24'h000003; v24 = 1'b1;
    n_cmp++;
    if (rdy24 !== 1'b1) begin n_err++; $display("FAIL dw24_ready: got %b want 1", rdy24); end
    rst24 = 1'b0; k2 = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); @(negedge clock); k2++;
      v24 = 1'b0;
      n_cmp++;
      if ({bclk24, fs24, ur24} !== {((k2 / 2) % 2) == 1, k2 == 4, 1'b0}) begin
        n_err++; $display("FAIL dw24_start_k%0d: got bclk/fs/ur=%b", k2, {bclk24, fs24, ur24});
      end
    end
    for (int b = 0; b < 64; b++) begin
      p = b % 32;
      w = (b < 32) ? 24'h800001 : 24'h000003;
      if (p >= 1 && p <= 24) e = w[24 - p]; else e = 1'b0;
      n_cmp++;
      if ({lrclk24, sdata24} !== {b >= 32, e}) begin
        n_err++; $display("FAIL dw24_bit%0d: got lrclk/sdata=%b want %b", b, {lrclk24, sdata24}, {b >= 32, e});
      end
      repeat (4) begin
        @(posedge clock); @(negedge clock); k2++;
        n_cmp++;
        if (bclk24 !== (((k2 / 2) % 2) == 1)) begin
          n_err++; $display("FAIL dw24_bclk_k%0d: got %b want %b", k2, bclk24, ((k2 / 2) % 2) == 1);
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; k = 0; acc_cnt = 0; idx = 0; b2b = 1'b0;
    reset = 1'b1; sampleValid = 1'b0; leftSample = 16'h0000; rightSample = 16'h0000;
    rst24 = 1'b1; v24 = 1'b0; l24 = 24'h000000; r24 = 24'h000000;
    pairs[0] = {16'h1234, 16'hFEDC};
    pairs[1] = {16'h8001, 16'h7FFE};
    pairs[2] = {16'h5555, 16'hAAAA};
    pairs[3] = {16'hC3A5, 16'h0180};
    pairs[4] = {16'hFFFF, 16'hFFFF};
    test_reset();
    test_idle_frame();
    test_single_pair();
    test_sim_accept();
    test_back_to_back();
    test_reset_mid();
    test_dw24();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
